// File: rtl/sys_ctrl.sv
// sys_ctrl: clock-enable divider, peripheral reset stretcher and tick-paced decoded bus controller
//   in : clk, rst_n (async active-low), addr, rd, wr, slave_ack[NUM_SLAVES]
//   out: clk_en (tick), sys_reset, cs (one-hot), slave_rd, slave_wr, ready, bus_err, err_addr
module sys_ctrl #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 16,
  parameter int DEC_W = 4,
  parameter int DIV_LOG2 = 4,
  parameter int RST_TICKS = 16,
  parameter int TIMEOUT = 15,
  parameter logic [NUM_SLAVES*DEC_W-1:0] SLAVE_BASE = {4'hF, 4'hA, 4'h9, 4'h0},
  parameter logic [NUM_SLAVES*DEC_W-1:0] SLAVE_MASK = {4'hF, 4'hF, 4'hF, 4'h8}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [NUM_SLAVES-1:0] slave_ack,
  output logic                  clk_en,
  output logic                  sys_reset,
  output logic [NUM_SLAVES-1:0] cs,
  output logic                  slave_rd,
  output logic                  slave_wr,
  output logic                  ready,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     err_addr
);
  localparam int DW = DIV_LOG2 > 0 ? DIV_LOG2 : 1;
  localparam int SW = $clog2(RST_TICKS + 1) > 0 ? $clog2(RST_TICKS + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1) > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] st_q, st_d;
  logic sys_reset_q, sys_reset_d;
  logic [NUM_SLAVES-1:0] hit_oh, cs_q, cs_d;
  logic slave_rd_q, slave_rd_d, slave_wr_q, slave_wr_d;
  logic ready_q, ready_d, bus_err_q, bus_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic req, req_ok, acked, tmo;
  // With DIV_LOG2=0 the divider is frozen at zero and every clk is a tick
  assign clk_en = (DIV_LOG2 == 0) || (div_q == '1);
  assign div_d = (DIV_LOG2 == 0) ? '0 : div_q + 1'b1;
  // Stretch counter only advances while sys_reset is still asserted
  always_comb begin
    st_d = (clk_en && sys_reset_q) ? st_q + 1'b1 : st_q;
    sys_reset_d = sys_reset_q && !(clk_en && int'(st_q) + 1 >= RST_TICKS);
  end
  // Scan from the top slot down so the lowest-index hit overwrites the rest
  always_comb begin
    hit_oh = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((addr[ADDR_W-1 -: DEC_W] & SLAVE_MASK[i*DEC_W +: DEC_W]) == SLAVE_BASE[i*DEC_W +: DEC_W]) begin
        hit_oh = '0;
        hit_oh[i] = 1'b1;
      end
  end
  assign req = !sys_reset_q && (rd || wr);
  assign req_ok = (rd ^ wr) && |hit_oh;
  assign acked = |(slave_ack & cs_q);
  assign tmo = int'(timer_q) + 1 >= TIMEOUT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (clk_en)
      case (state_q)
        IDLE:    if (req) state_d = req_ok ? ACCESS : DONE;
        ACCESS:  if (acked || tmo) state_d = DONE;
        DONE:    if (!rd && !wr) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    cs_d = cs_q;
    slave_rd_d = slave_rd_q;
    slave_wr_d = slave_wr_q;
    ready_d = ready_q;
    bus_err_d = bus_err_q;
    err_addr_d = err_addr_q;
    timer_d = timer_q;
    if (clk_en)
      case (state_q)
        IDLE: if (req) begin
          if (req_ok) begin
            cs_d = hit_oh;
            slave_rd_d = rd;
            slave_wr_d = wr;
            timer_d = '0;
          end else begin
            ready_d = 1'b1;
            bus_err_d = 1'b1;
            err_addr_d = addr;
          end
        end
        ACCESS: begin
          // An ack on the final timer tick still counts as success
          timer_d = acked ? timer_q : timer_q + 1'b1;
          if (acked || tmo) begin
            cs_d = '0;
            slave_rd_d = 1'b0;
            slave_wr_d = 1'b0;
            ready_d = 1'b1;
            bus_err_d = !acked;
            err_addr_d = acked ? err_addr_q : addr;
          end
        end
        // Status pulses last exactly one tick regardless of the held strobes
        DONE: begin
          ready_d = 1'b0;
          bus_err_d = 1'b0;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q <= '0;
      st_q <= '0;
      sys_reset_q <= 1'b1;
      cs_q <= '0;
      slave_rd_q <= 1'b0;
      slave_wr_q <= 1'b0;
      ready_q <= 1'b0;
      bus_err_q <= 1'b0;
      err_addr_q <= '0;
      timer_q <= '0;
    end else begin
      div_q <= div_d;
      st_q <= st_d;
      sys_reset_q <= sys_reset_d;
      cs_q <= cs_d;
      slave_rd_q <= slave_rd_d;
      slave_wr_q <= slave_wr_d;
      ready_q <= ready_d;
      bus_err_q <= bus_err_d;
      err_addr_q <= err_addr_d;
      timer_q <= timer_d;
    end
  assign sys_reset = sys_reset_q;
  assign cs = cs_q;
  assign slave_rd = slave_rd_q;
  assign slave_wr = slave_wr_q;
  assign ready = ready_q;
  assign bus_err = bus_err_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed and randomized transaction checks of sys_ctrl against a transaction-level model
module tb_sys_ctrl;
  localparam int TICK = 16;
  localparam int TMO = 15;
  localparam logic [3:0] BASE [4] = '{4'h0, 4'h9, 4'hA, 4'hF};
  localparam logic [3:0] MASK [4] = '{4'h8, 4'hF, 4'hF, 4'hF};
  logic clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0] slave_ack = '0;
  logic clk_en, sys_reset, slave_rd, slave_wr, ready, bus_err;
  logic [3:0] cs;
  logic [15:0] err_addr;
  int total = 0, bad = 0;
  logic [15:0] last_err = '0;
  sys_ctrl dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .slave_ack(slave_ack),
    .clk_en(clk_en), .sys_reset(sys_reset), .cs(cs), .slave_rd(slave_rd), .slave_wr(slave_wr),
    .ready(ready), .bus_err(bus_err), .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int decode(input logic [15:0] a);
    for (int i = 0; i < 4; i++)
      if ((a[15:12] & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction
  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask
  // One CPU transaction; ack_tick counts ACCESS ticks, values beyond TMO mean never acked
  task automatic run_txn(input logic [15:0] a, input logic r, input logic w, input int ack_tick, input bit hold);
    int slot, n, cs_clks, ticks, rdy_clks;
    bit bad_req, err, seen;
    logic [3:0] exp_cs, noise;
    slot = decode(a);
    bad_req = (r && w) || slot < 0;
    exp_cs = bad_req ? 4'b0 : 4'(1 << slot);
    err = bad_req || ack_tick > TMO;
    @(negedge clk);
    addr = a; rd = r; wr = w; slave_ack = '0;
    n = 0;
    while (cs == 0 && !ready && n < 40) begin tick_clk(); n++; end
    chk("start_within_tick", 32'(n <= TICK), 32'd1);
    chk("cs_onehot", 32'(cs), 32'(exp_cs));
    if (!bad_req) begin
      chk("slave_rd", 32'(slave_rd), 32'(r));
      chk("slave_wr", 32'(slave_wr), 32'(w));
      cs_clks = 0; ticks = 0;
      while (cs != 0 && cs_clks < 400) begin
        noise = 4'($urandom) & ~exp_cs;
        if (clk_en) begin
          ticks++;
          slave_ack = noise | ((ticks == ack_tick) ? exp_cs : 4'b0);
        end else slave_ack = noise | (($urandom_range(0, 1) == 1) ? exp_cs : 4'b0);
        tick_clk();
        cs_clks++;
      end
      slave_ack = '0;
      chk("cs_len", 32'(cs_clks), 32'(TICK * (ack_tick <= TMO ? ack_tick : TMO)));
      chk("strobes_dropped", 32'({slave_rd, slave_wr}), 32'd0);
    end
    chk("ready", 32'(ready), 32'd1);
    chk("bus_err", 32'(bus_err), 32'(err));
    if (err) last_err = a;
    chk("err_addr", 32'(err_addr), 32'(last_err));
    if (!hold) begin rd = 1'b0; wr = 1'b0; end
    rdy_clks = 0;
    while (ready && rdy_clks < 100) begin tick_clk(); rdy_clks++; end
    chk("ready_len", 32'(rdy_clks), 32'(TICK));
    if (hold) begin
      seen = 1'b0;
      repeat (3 * TICK) begin tick_clk(); if (ready || cs != 0) seen = 1'b1; end
      chk("no_reissue", 32'(seen), 32'd0);
      rd = 1'b0; wr = 1'b0;
      repeat (TICK + 4) tick_clk();
    end
  endtask
  initial begin
    int n, en_err;
    bit saw_cs, seen;
    logic [15:0] ra;
    addr = 16'h0010; rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sys_reset", 32'(sys_reset), 32'd1);
    chk("rst_outputs", 32'({cs, slave_rd, slave_wr, ready, bus_err}), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; en_err = 0; saw_cs = 1'b0;
    while (sys_reset && n < 400) begin
      tick_clk();
      n++;
      if (cs != 0) saw_cs = 1'b1;
      if (clk_en !== (n % TICK == TICK - 1)) en_err++;
    end
    chk("stretch_clks", 32'(n), 32'(TICK * 16));
    chk("no_cs_in_stretch", 32'(saw_cs), 32'd0);
    chk("clk_en_phase", 32'(en_err), 32'd0);
    run_txn(16'h0010, 1'b1, 1'b0, 1, 1'b0);
    run_txn(16'h9000, 1'b0, 1'b1, 3, 1'b0);
    run_txn(16'hB000, 1'b1, 1'b0, 1, 1'b0);
    run_txn(16'hF000, 1'b1, 1'b0, 99, 1'b0);
    run_txn(16'hA123, 1'b1, 1'b0, TMO, 1'b0);
    run_txn(16'h7FFF, 1'b0, 1'b1, 2, 1'b0);
    run_txn(16'h8000, 1'b1, 1'b0, 1, 1'b0);
    run_txn(16'h0040, 1'b1, 1'b1, 1, 1'b1);
    run_txn(16'h9ABC, 1'b1, 1'b0, 2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      ra = 16'($urandom);
      n = $urandom_range(0, 2);
      run_txn(ra, n != 1, n != 0, $urandom_range(1, 18), $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    addr = 16'h9000; wr = 1'b1;
    n = 0;
    while (cs == 0 && n < 40) begin tick_clk(); n++; end
    chk("pre_abort_cs", 32'(cs), 32'b0010);
    repeat (20) tick_clk();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'd0);
    chk("abort_sys_reset", 32'(sys_reset), 32'd1);
    chk("abort_strobes", 32'({slave_rd, slave_wr, ready, bus_err}), 32'd0);
    seen = 1'b0;
    repeat (5) begin tick_clk(); if (ready) seen = 1'b1; end
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * TICK) begin tick_clk(); if (ready) seen = 1'b1; end
    chk("abort_no_ready", 32'(seen), 32'd0);
    chk("stretch_restarted", 32'(sys_reset), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
